// File: rtl/tick_timer_sched.sv
// Multi-channel countdown timer scheduler with a shared prescaler
// and a round-robin valid/ready expiry event port.
module tick_timer_sched #(
  parameter int PRESC = 50000,
  parameter int NCH   = 4,
  parameter int CW    = 16,
  parameter int CHW   = 2
) (
  input  logic           clk50m,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_periodic,
  input  logic           cfg_stop,
  output logic           tick,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CHW-1:0] evt_ch,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] overrun
);

  localparam int PW = $clog2(PRESC);
  localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);

  typedef enum logic {
    IDLE,
    PRESENT
  } st_t;

  st_t            state_q, state_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  reload_q [NCH];
  logic [CW-1:0]  reload_d [NCH];
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] active_q, active_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [CHW-1:0] evt_ch_q, evt_ch_d;
  logic [CHW-1:0] lg_q, lg_d;
  logic [CHW-1:0] pick;
  logic           found;
  logic           acc;
  logic           hs;

  assign tick      = (pcnt_q == PMAX);
  assign cfg_ready = rst_n & ~tick;
  assign acc       = cfg_valid & cfg_ready;
  assign hs        = evt_valid & evt_ready;
  assign evt_ch    = evt_ch_q;
  assign active    = active_q;
  assign overrun   = ovr_q;

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
  end

  // A same-cycle expiry overrides the handshake clear of that channel.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    active_d = active_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    if (hs) pend_d[evt_ch_q] = 1'b0;
    if (acc) begin
      ovr_d[cfg_ch] = 1'b0;
      if (cfg_stop || cfg_period == '0) begin
        active_d[cfg_ch] = 1'b0;
        cnt_d[cfg_ch]    = '0;
        pend_d[cfg_ch]   = 1'b0;
      end else begin
        cnt_d[cfg_ch]    = cfg_period;
        reload_d[cfg_ch] = cfg_period;
        mode_d[cfg_ch]   = cfg_periodic;
        active_d[cfg_ch] = 1'b1;
      end
    end
    if (tick) begin
      for (int c = 0; c < NCH; c++) begin
        if (active_q[c]) begin
          if (cnt_q[c] == CW'(1)) begin
            if (pend_q[c] && !(hs && evt_ch_q == CHW'(c)))
              ovr_d[c] = 1'b1;
            pend_d[c] = 1'b1;
            if (mode_q[c]) begin
              cnt_d[c] = reload_q[c];
            end else begin
              cnt_d[c]    = '0;
              active_d[c] = 1'b0;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
      end
    end
  end

  // Scan upward from the channel after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && pend_q[(int'(lg_q) + i) % NCH]) begin
        found = 1'b1;
        pick  = CHW'((int'(lg_q) + i) % NCH);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    lg_d     = lg_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = PRESENT;
          evt_ch_d = pick;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          state_d = IDLE;
          lg_d    = evt_ch_q;
        end
      end
    endcase
  end

  always_comb begin
    evt_valid = (state_q == PRESENT);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      mode_q   <= '0;
      active_q <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      evt_ch_q <= '0;
      lg_q     <= CHW'(NCH - 1);
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= '0;
        reload_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      evt_ch_q <= evt_ch_d;
      lg_q     <= lg_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        reload_q[c] <= reload_d[c];
      end
    end
  end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Scoreboard bench for tick_timer_sched: a cycle-level rule model
// predicts presented events; a monitor pops them on each handshake.
module tb_tick_timer_sched;

  localparam int P   = 8;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_periodic = 1'b0;
  logic           cfg_stop = 1'b0;
  logic           tick;
  logic           evt_valid;
  logic           evt_ready = 1'b0;
  logic [CHW-1:0] evt_ch;
  logic [NCH-1:0] active;
  logic [NCH-1:0] overrun;

  tick_timer_sched #(
    .PRESC(P), .NCH(NCH), .CW(CW), .CHW(CHW)
  ) dut (
    .clk50m(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_periodic(cfg_periodic), .cfg_stop(cfg_stop),
    .tick(tick), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_ch(evt_ch),
    .active(active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int exp_q[$];
  int seen[$];
  int seen_t[$];

  task automatic chk(string nm, int a, int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Reference model: timers as integer counts, arbiter as a modulo scan.
  int  m_pcnt;
  int  m_cnt [NCH];
  int  m_rel [NCH];
  bit  m_per [NCH];
  bit  m_act [NCH];
  bit  m_pend [NCH];
  bit  m_ovr [NCH];
  bit  m_ev;
  int  m_ch;
  int  m_lg;
  bit  tk, acc, hs, fnd;
  bit  np [NCH];
  int  cc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt = 0;
      m_ev   = 0;
      m_ch   = 0;
      m_lg   = NCH - 1;
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_rel[c] = 0; m_per[c] = 0;
        m_act[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      end
      exp_q.delete();
    end else begin
      cyc_n++;
      tk  = (m_pcnt == P - 1);
      acc = cfg_valid && !tk;
      hs  = m_ev && evt_ready;
      np  = m_pend;
      if (hs) np[m_ch] = 0;
      if (acc) begin
        cc = int'(cfg_ch);
        m_ovr[cc] = 0;
        if (cfg_stop || cfg_period == 0) begin
          m_act[cc] = 0; m_cnt[cc] = 0; np[cc] = 0;
        end else begin
          m_cnt[cc] = int'(cfg_period);
          m_rel[cc] = int'(cfg_period);
          m_per[cc] = cfg_periodic;
          m_act[cc] = 1;
        end
      end
      if (tk) begin
        for (int c = 0; c < NCH; c++) begin
          if (m_act[c]) begin
            if (m_cnt[c] == 1) begin
              if (m_pend[c] && !(hs && m_ch == c)) m_ovr[c] = 1;
              np[c] = 1;
              if (m_per[c]) m_cnt[c] = m_rel[c];
              else begin m_cnt[c] = 0; m_act[c] = 0; end
            end else begin
              m_cnt[c] = m_cnt[c] - 1;
            end
          end
        end
      end
      if (m_ev) begin
        if (hs) begin m_ev = 0; m_lg = m_ch; end
      end else begin
        fnd = 0;
        for (int k = 1; k <= NCH; k++) begin
          cc = (m_lg + k) % NCH;
          if (!fnd && m_pend[cc]) begin
            fnd = 1; m_ev = 1; m_ch = cc;
            exp_q.push_back(cc);
          end
        end
      end
      m_pend = np;
      m_pcnt = tk ? 0 : m_pcnt + 1;
    end
  end

  function automatic int vec(bit v [NCH]);
    int r = 0;
    for (int c = 0; c < NCH; c++) if (v[c]) r |= (1 << c);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tick", int'(tick), int'(m_pcnt == P - 1));
      chk("cfg_ready", int'(cfg_ready), int'(m_pcnt != P - 1));
      chk("active", int'(active), vec(m_act));
      chk("overrun", int'(overrun), vec(m_ovr));
      chk("evt_valid", int'(evt_valid), int'(m_ev));
      if (m_ev) chk("evt_ch", int'(evt_ch), m_ch);
      if (evt_valid && evt_ready) begin
        seen.push_back(int'(evt_ch));
        seen_t.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          chk("evt_unexpected", int'(evt_ch), -1);
        end else begin
          chk("evt_sb", int'(evt_ch), exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(int ch, int per, bit pm, bit st);
    int g = 0;
    cfg_valid    = 1'b1;
    cfg_ch       = CHW'(ch);
    cfg_period   = CW'(per);
    cfg_periodic = pm;
    cfg_stop     = st;
    while (!cfg_ready && g < 20) begin
      step();
      g++;
    end
    if (g == 20) chk("cfg_timeout", g, 0);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int g = 0;
    while (!tick && g < 4 * P) begin
      step();
      g++;
    end
    if (g == 4 * P) chk("tick_timeout", g, 0);
  endtask

  task automatic do_reset();
    int n = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_overrun", int'(overrun), 0);
    step(2);
    rst_n = 1'b1;
    while (!tick && n < 4 * P) begin
      step();
      n++;
    end
    chk("first_tick", n, P - 1);
  endtask

  task automatic rr_round();
    wait_tick();
    step();
    seen.delete();
    seen_t.delete();
    for (int c = NCH - 1; c >= 0; c--) cfg(c, 1, 0, 0);
    step(3 * P);
    chk("rr_count", seen.size(), NCH);
    for (int i = 0; i < NCH && i < seen.size(); i++)
      chk("rr_order", seen[i], i);
    for (int i = 1; i < seen_t.size(); i++)
      chk("rr_gap", seen_t[i] - seen_t[i-1], 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    do_reset();
    cfg(0, 5, 0, 0);
    step(6);
    do_reset();

    // one-shot
    evt_ready = 1'b1;
    seen.delete();
    cfg(0, 3, 0, 0);
    chk("os_active", int'(active[0]), 1);
    step(4 * P);
    chk("os_events", seen.size(), 1);
    if (seen.size() > 0) chk("os_ch", seen[0], 0);
    chk("os_idle", int'(active[0]), 0);

    // periodic, then stop
    seen.delete();
    seen_t.delete();
    cfg(1, 2, 1, 0);
    step(8 * P);
    chk("per_active", int'(active[1]), 1);
    chk("per_min", int'(seen.size() >= 3), 1);
    for (int i = 1; i < seen_t.size(); i++)
      chk("per_gap", seen_t[i] - seen_t[i-1], 2 * P);
    cfg(1, 0, 0, 1);
    step(4);
    seen.delete();
    step(6 * P);
    chk("stop_quiet", seen.size(), 0);

    // round-robin from reset, then again after last_grant=3
    do_reset();
    evt_ready = 1'b1;
    rr_round();
    rr_round();

    // overrun under backpressure
    do_reset();
    evt_ready = 1'b0;
    cfg(0, 1, 1, 0);
    step(3 * P);
    chk("ovr_set", int'(overrun[0]), 1);
    chk("ovr_valid", int'(evt_valid), 1);
    chk("ovr_ch", int'(evt_ch), 0);
    cfg(0, 1, 1, 0);
    chk("ovr_clr", int'(overrun[0]), 0);
    cfg(0, 0, 0, 1);
    evt_ready = 1'b1;
    step(10);

    // request held across a tick cycle
    wait_tick();
    cfg_valid = 1'b1;
    cfg_ch = 2'd2;
    cfg_period = 16'd5;
    cfg_periodic = 1'b0;
    cfg_stop = 1'b0;
    chk("tk_ready", int'(cfg_ready), 0);
    step();
    chk("tk_ready_next", int'(cfg_ready), 1);
    chk("tk_not_yet", int'(active[2]), 0);
    step();
    cfg_valid = 1'b0;
    chk("tk_loaded", int'(active[2]), 1);
    cfg(2, 0, 0, 1);

    // stop on a pending, not-yet-presented channel
    do_reset();
    evt_ready = 1'b0;
    step();
    cfg(0, 1, 0, 0);
    cfg(1, 1, 0, 0);
    wait_tick();
    step(3);
    chk("sp_valid", int'(evt_valid), 1);
    chk("sp_ch", int'(evt_ch), 0);
    cfg(1, 0, 0, 1);
    seen.delete();
    evt_ready = 1'b1;
    step(10);
    chk("sp_count", seen.size(), 1);
    if (seen.size() > 0) chk("sp_only0", seen[0], 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_ch       = CHW'($urandom_range(0, NCH - 1));
      cfg_period   = ($urandom_range(0, 9) == 0) ? '0 :
                     CW'($urandom_range(1, 5));
      cfg_periodic = 1'($urandom_range(0, 1));
      cfg_stop     = ($urandom_range(0, 7) == 0);
      evt_ready    = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        cfg_valid = 1'b0;
        do_reset();
      end
      step();
    end

    cfg_valid = 1'b0;
    for (int c = 0; c < NCH; c++) cfg(c, 0, 0, 1);
    evt_ready = 1'b1;
    step(10);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
